// File: rtl/branch_predictor_bht_if.sv
// ----------------------------------------------------------------------------
// branch_predictor_bht_if
//
// Bundles the fetch-side lookup, execute-side training and statistics signals
// of the branch history table. Clock and reset stay outside the interface.
//
// Parameters:
//   IDX_W           width of a table index (log2 of the number of counters)
//
// Signals:
//   pred_valid      fetch requests a lookup this cycle
//   pred_pc         PC of the fetched instruction
//   pred_out_valid  registered: a prediction is presented this cycle
//   pred_taken      registered predicted direction
//   pred_index      registered table index, carried down the pipeline
//   upd_valid       a conditional branch resolved this cycle
//   upd_index       pred_index that travelled with that branch
//   upd_taken       resolved outcome from the branch comparator
//   upd_pred_taken  prediction that travelled with that branch
//   mispredict      combinational: resolved outcome disagrees with prediction
//   branch_count    resolved branches since reset
//   mispred_count   mispredicted branches since reset
//
// Modports: master = pipeline side (fetch + execute), slave = predictor.
// ----------------------------------------------------------------------------
interface branch_predictor_bht_if #(
    parameter int IDX_W = 6
);
    logic             pred_valid;
    logic [31:0]      pred_pc;
    logic             pred_out_valid;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_index;

    logic             upd_valid;
    logic [IDX_W-1:0] upd_index;
    logic             upd_taken;
    logic             upd_pred_taken;
    logic             mispredict;

    logic [31:0]      branch_count;
    logic [31:0]      mispred_count;

    modport master (
        output pred_valid,
        output pred_pc,
        input  pred_out_valid,
        input  pred_taken,
        input  pred_index,
        output upd_valid,
        output upd_index,
        output upd_taken,
        output upd_pred_taken,
        input  mispredict,
        input  branch_count,
        input  mispred_count
    );

    modport slave (
        input  pred_valid,
        input  pred_pc,
        output pred_out_valid,
        output pred_taken,
        output pred_index,
        input  upd_valid,
        input  upd_index,
        input  upd_taken,
        input  upd_pred_taken,
        output mispredict,
        output branch_count,
        output mispred_count
    );
endinterface

// File: rtl/branch_predictor_bht.sv
// ----------------------------------------------------------------------------
// branch_predictor_bht
//
// Branch history table of ENTRIES 2-bit saturating counters. A lookup from
// fetch returns a registered direction and index one cycle later; resolved
// branches from execute train the addressed counter and feed the statistics
// counters. A combinational mispredict flag compares the resolved outcome
// with the prediction that travelled down the pipeline.
//
// Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
// Predict taken iff bit 1 of the counter is set.
//
// Optional feature (macro BHT_GSHARE_EN):
//   defined     a GHR_BITS-wide global history register, updated only at
//               resolution, is XORed into the lookup index (gshare).
//   undefined   the lookup index is pred_pc[IDX_W+1:2] alone; no GHR.
//
// Parameters:
//   ENTRIES   number of counters, power of two, 4..1024
//   GHR_BITS  global history length, 1..IDX_W (used only with gshare)
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   branch_predictor_bht_if.slave: lookup, training and statistics
// ----------------------------------------------------------------------------
module branch_predictor_bht #(
    parameter  int ENTRIES  = 64,
    parameter  int GHR_BITS = 6,
    localparam int IDX_W    = $clog2(ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_predictor_bht_if.slave bus
);

    // Elaboration-time parameter sanity.
    if ((ENTRIES & (ENTRIES - 1)) != 0 || ENTRIES < 4 || ENTRIES > 1024) begin : g_bad_entries
        $error("branch_predictor_bht: ENTRIES must be a power of two in 4..1024");
    end
    if (GHR_BITS < 1 || GHR_BITS > IDX_W) begin : g_bad_ghr
        $error("branch_predictor_bht: GHR_BITS must be in 1..IDX_W");
    end

    localparam logic [1:0] CTR_RESET = 2'b01;

    // Saturating step of a 2-bit direction counter.
    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'b01;
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       ctr_q [ENTRIES];
    logic [1:0]       upd_ctr_d;

    logic             pred_out_valid_q;
    logic             pred_taken_q;
    logic [IDX_W-1:0] pred_index_q;
    logic             pred_taken_d;
    logic [IDX_W-1:0] pred_index_d;

    logic [31:0]      branch_count_q;
    logic [31:0]      mispred_count_q;
    logic [31:0]      branch_count_d;
    logic [31:0]      mispred_count_d;

    logic             mispredict;
    logic [IDX_W-1:0] pc_idx;
    logic [IDX_W-1:0] lookup_idx;

    // PC bits outside the word-aligned index field do not affect the table.
    logic             unused_pc_bits;
    assign unused_pc_bits = ^{bus.pred_pc[31:IDX_W+2], bus.pred_pc[1:0]};

    assign pc_idx = bus.pred_pc[IDX_W+1:2];

    // ------------------------------------------------------------------------
    // Index formation
    // ------------------------------------------------------------------------
`ifdef BHT_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q;
    logic [GHR_BITS-1:0] ghr_d;

    // Shift left, newest outcome in bit 0; the cast drops the oldest bit and
    // also handles GHR_BITS == 1 without a negative slice.
    always_comb begin
        ghr_d = ghr_q;
        if (bus.upd_valid) begin
            ghr_d = GHR_BITS'({ghr_q, bus.upd_taken});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign lookup_idx = pc_idx ^ IDX_W'(ghr_q);
`else
    assign lookup_idx = pc_idx;
`endif

    // ------------------------------------------------------------------------
    // Lookup stage -> registered prediction outputs
    // ------------------------------------------------------------------------
    // The array read sees the value before any same-edge update, giving
    // read-before-write behaviour with no bypass.
    always_comb begin
        pred_taken_d = pred_taken_q;
        pred_index_d = pred_index_q;
        if (bus.pred_valid) begin
            pred_taken_d = ctr_q[lookup_idx][1];
            pred_index_d = lookup_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_out_valid_q <= 1'b0;
            pred_taken_q     <= 1'b0;
            pred_index_q     <= '0;
        end else begin
            pred_out_valid_q <= bus.pred_valid;
            pred_taken_q     <= pred_taken_d;
            pred_index_q     <= pred_index_d;
        end
    end

    // ------------------------------------------------------------------------
    // Training stage -> counter array
    // ------------------------------------------------------------------------
    assign upd_ctr_d = sat_step(ctr_q[bus.upd_index], bus.upd_taken);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_RESET;
            end
        end else if (bus.upd_valid) begin
            ctr_q[bus.upd_index] <= upd_ctr_d;
        end
    end

    // ------------------------------------------------------------------------
    // Resolution flag and statistics
    // ------------------------------------------------------------------------
    assign mispredict = bus.upd_valid & (bus.upd_taken != bus.upd_pred_taken);

    always_comb begin
        branch_count_d  = branch_count_q;
        mispred_count_d = mispred_count_q;
        if (bus.upd_valid) begin
            branch_count_d = branch_count_q + 32'd1;
        end
        if (mispredict) begin
            mispred_count_d = mispred_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count_q  <= '0;
            mispred_count_q <= '0;
        end else begin
            branch_count_q  <= branch_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.pred_out_valid = pred_out_valid_q;
    assign bus.pred_taken     = pred_taken_q;
    assign bus.pred_index     = pred_index_q;
    assign bus.mispredict     = mispredict;
    assign bus.branch_count   = branch_count_q;
    assign bus.mispred_count  = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// ----------------------------------------------------------------------------
// tb_branch_predictor_bht
//
// Scoreboard bench for branch_predictor_bht (ENTRIES=64, GHR_BITS=6). The
// driver keeps a table of integer confidence levels (0..3), a history value
// and branch/mispredict tallies; every lookup pushes its expected direction
// and index into a queue, and a monitor on the falling edge pops and compares
// whenever the DUT presents a prediction. Build with +define+BHT_GSHARE_EN to
// exercise the gshare variant.
// ----------------------------------------------------------------------------
module tb_branch_predictor_bht;

    localparam int ENT   = 64;
    localparam int IW    = 6;
    localparam int GBITS = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    branch_predictor_bht_if #(.IDX_W(IW)) bus ();

    branch_predictor_bht #(
        .ENTRIES (ENT),
        .GHR_BITS(GBITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic          taken;
        logic [IW-1:0] idx;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference state: confidence level per entry, history, tallies.
    int          level [ENT];
    int          hist;
    logic [31:0] m_branches;
    logic [31:0] m_mispreds;

    // Update presented for the coming edge, and the lookup awaiting push.
    bit          cur_uv, cur_ut, cur_upt;
    int          cur_ui;
    bit          pend_v;
    exp_t        pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) level[i] = 1;
        hist       = 0;
        m_branches = 0;
        m_mispreds = 0;
        cur_uv     = 0;
        pend_v     = 0;
        exp_q.delete();
    endtask

    // One clock cycle: account for the edge, then drive the next inputs.
    task automatic step(input bit r, input bit pv, input logic [31:0] pc,
                        input bit uv, input int ui, input bit ut, input bit upt);
        int idx;
        @(posedge clk);
        if (!rst) begin
            if (pend_v) exp_q.push_back(pend);
            if (cur_uv) begin
                if (cur_ut) level[cur_ui] = (level[cur_ui] < 3) ? level[cur_ui] + 1 : 3;
                else        level[cur_ui] = (level[cur_ui] > 0) ? level[cur_ui] - 1 : 0;
                m_branches = m_branches + 1;
                if (cur_ut != cur_upt) m_mispreds = m_mispreds + 1;
                hist = ((hist * 2) + int'(cur_ut)) % (1 << GBITS);
            end
        end
        pend_v = 0;
        #1;
        rst                = r;
        bus.pred_valid     = pv;
        bus.pred_pc        = pc;
        bus.upd_valid      = uv;
        bus.upd_index      = IW'(ui);
        bus.upd_taken      = ut;
        bus.upd_pred_taken = upt;
        if (r) model_reset();
        cur_uv  = uv && !r;
        cur_ui  = ui;
        cur_ut  = ut;
        cur_upt = upt;
        if (pv && !r) begin
            idx = int'(pc[IW+1:2]);
`ifdef BHT_GSHARE_EN
            idx = idx ^ hist;
`endif
            pend.idx   = IW'(idx);
            pend.taken = (level[idx] >= 2);
            pend_v     = 1;
        end
        #1;
        chk("mispredict", {31'd0, bus.mispredict}, {31'd0, (uv && (ut != upt))});
    endtask

    // Monitor: compare presented predictions and statistics on falling edges.
    always @(negedge clk) begin
        exp_t e;
        chk("pred_out_valid", {31'd0, bus.pred_out_valid}, {31'd0, (exp_q.size() != 0)});
        if (bus.pred_out_valid && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pred_taken", {31'd0, bus.pred_taken}, {31'd0, e.taken});
            chk("pred_index", 32'(bus.pred_index), 32'(e.idx));
        end
        chk("branch_count", bus.branch_count, m_branches);
        chk("mispred_count", bus.mispred_count, m_mispreds);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.pred_valid     = 1'b0;
        bus.pred_pc        = 32'd0;
        bus.upd_valid      = 1'b0;
        bus.upd_index      = '0;
        bus.upd_taken      = 1'b0;
        bus.upd_pred_taken = 1'b0;
        model_reset();

        // Reset, then idle.
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 3, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("reset pred_taken", {31'd0, bus.pred_taken}, 32'd0);
        chk("reset pred_index", 32'(bus.pred_index), 32'd0);

        // First lookup; then train index 0 taken with a mispredict.
        step(0, 1, 32'h100, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1, 0);
        step(0, 1, 32'h100, 0, 0, 0, 0);
        step(0, 1, 32'h104, 0, 0, 0, 0);

        // Saturation on index 5.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 5, 1, 1);
        step(0, 0, 0, 1, 5, 0, 1);
        step(0, 1, 32'h114, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 5, 0, 0);
        step(0, 1, 32'h114, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 5, 0, 0);
        step(0, 1, 32'h114, 1, 9, 1, 1);

        // Same-edge lookup and update to index 0 from reset.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h100, 1, 0, 1, 1);
        step(0, 1, 32'h100, 0, 0, 0, 0);

        // History pattern taken, taken, not-taken then lookup 0x100.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 1, 0);
        step(0, 0, 0, 1, 2, 1, 1);
        step(0, 0, 0, 1, 3, 0, 1);
        step(0, 1, 32'h100, 0, 0, 0, 0);

        // Randomised traffic with occasional mid-run resets.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pc;
            int          ui;
            bit          r;
            r  = ($urandom_range(0, 399) == 0);
            pc = $urandom;
            if ($urandom_range(0, 1) == 1) pc[31:5] = '0;
            ui = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7))
                                             : int'($urandom_range(0, ENT - 1));
            step(r, bit'($urandom_range(0, 1)), pc, bit'($urandom_range(0, 2) != 0), ui,
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        // Drain.
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
